inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/fetch_pkg.sv | 13 +
 rtl/inst_fetch.sv | 130 +++++++++++++
 tb/tb_inst_fetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-unit state encoding and default widths
package fetch_pkg;

    localparam int FETCH_ADDR_W_DEFAULT = 10;
    localparam int FETCH_INST_W_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit with ready/valid output register
// Optional retired-instruction counter port InstCount when FETCH_INST_CNT_EN is defined.
import fetch_pkg::*;

module inst_fetch #(
    parameter int A = FETCH_ADDR_W_DEFAULT,
    parameter int W = FETCH_INST_W_DEFAULT
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [A-1:0] StartAddr,
    output logic [A-1:0] InstAddress,
    input  logic [W-1:0] InstIn,
    output logic [W-1:0] InstOut,
    output logic [A-1:0] PcOut,
    output logic         InstValid,
    input  logic         InstReady,
    input  logic         BranchEn,
    input  logic [A-1:0] BranchTarget,
    input  logic         Halt,
    output logic         Done
`ifdef FETCH_INST_CNT_EN
    ,
    output logic [31:0]  InstCount
`endif
);

    localparam logic [A-1:0] PC_ONE = {{(A-1){1'b0}}, 1'b1};

    fetch_state_e state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [W-1:0] inst_q, inst_d;
    logic [A-1:0] pcout_q, pcout_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;
    logic         start_accept;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            pcout_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Priority inside RUN: Halt, then branch flush, then fetch/stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        pcout_d      = pcout_q;
        valid_d      = valid_q;
        done_d       = done_q;
        start_accept = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                valid_d = 1'b0;
                if (Start) begin
                    start_accept = 1'b1;
                    pc_d         = StartAddr;
                    done_d       = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (Halt) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = HALTED;
                end else if (BranchEn) begin
                    pc_d    = BranchTarget;
                    valid_d = 1'b0;
                end else if (!valid_q || InstReady) begin
                    inst_d  = InstIn;
                    pcout_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

`ifdef FETCH_INST_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start_accept) begin
            cnt_d = '0;
        end else if (valid_q && InstReady && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign InstCount = cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

    assign InstAddress = pc_q;
    assign InstOut     = inst_q;
    assign PcOut       = pcout_q;
    assign InstValid   = valid_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    localparam int A = 10;
    localparam int W = 9;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic [A-1:0] StartAddr;
    logic [A-1:0] InstAddress;
    logic [W-1:0] InstIn;
    logic [W-1:0] InstOut;
    logic [A-1:0] PcOut;
    logic         InstValid;
    logic         InstReady;
    logic         BranchEn;
    logic [A-1:0] BranchTarget;
    logic         Halt;
    logic         Done;
`ifdef FETCH_INST_CNT_EN
    logic [31:0]  InstCount;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    inst_fetch #(.A(A), .W(W)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .StartAddr    (StartAddr),
        .InstAddress  (InstAddress),
        .InstIn       (InstIn),
        .InstOut      (InstOut),
        .PcOut        (PcOut),
        .InstValid    (InstValid),
        .InstReady    (InstReady),
        .BranchEn     (BranchEn),
        .BranchTarget (BranchTarget),
        .Halt         (Halt),
        .Done         (Done)
`ifdef FETCH_INST_CNT_EN
        ,
        .InstCount    (InstCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM contents: low 9 address bits XOR 9'h155.
    function automatic logic [W-1:0] rom(input logic [A-1:0] a);
        return a[W-1:0] ^ 9'h155;
    endfunction

    assign InstIn = rom(InstAddress);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n      = 1'b0;
        Start        = 1'b0;
        StartAddr    = '0;
        InstReady    = 1'b0;
        BranchEn     = 1'b0;
        BranchTarget = '0;
        Halt         = 1'b0;
        #12;
        check("rst_valid", 32'(InstValid), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_pcout", 32'(PcOut), 32'd0);
        check("rst_instout", 32'(InstOut), 32'd0);
        check("rst_addr", 32'(InstAddress), 32'd0);
`ifdef FETCH_INST_CNT_EN
        check("rst_count", InstCount, 32'd0);
`endif
        tick();
        Reset_n = 1'b1;
        tick();
        check("idle_no_fetch", 32'(InstValid), 32'd0);

        // Start at 5 with decode always ready
        Start = 1'b1; StartAddr = 10'd5; InstReady = 1'b1;
        tick();
        Start = 1'b0;
        check("start_addr", 32'(InstAddress), 32'd5);
        check("start_valid0", 32'(InstValid), 32'd0);
        tick();
        check("f5_valid", 32'(InstValid), 32'd1);
        check("f5_pc", 32'(PcOut), 32'd5);
        check("f5_inst", 32'(InstOut), 32'h150);
        tick();
        check("f6_pc", 32'(PcOut), 32'd6);
        check("f6_inst", 32'(InstOut), 32'h153);
        tick();
        check("f7_pc", 32'(PcOut), 32'd7);
        check("f7_inst", 32'(InstOut), 32'h152);
        check("f7_addr", 32'(InstAddress), 32'd8);

        // Stall three cycles
        InstReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 32'(PcOut), 32'd7);
            check("stall_inst", 32'(InstOut), 32'h152);
            check("stall_addr", 32'(InstAddress), 32'd8);
            check("stall_valid", 32'(InstValid), 32'd1);
        end
        InstReady = 1'b1;
        tick();
        check("resume_pc", 32'(PcOut), 32'd8);
        check("resume_inst", 32'(InstOut), 32'h15D);

        // Branch while stalled
        InstReady = 1'b0; BranchEn = 1'b1; BranchTarget = 10'd100;
        tick();
        BranchEn = 1'b0;
        check("br_valid0", 32'(InstValid), 32'd0);
        check("br_addr", 32'(InstAddress), 32'd100);
        tick();
        check("br_valid1", 32'(InstValid), 32'd1);
        check("br_pc", 32'(PcOut), 32'd100);
        check("br_inst", 32'(InstOut), 32'h131);
        InstReady = 1'b1;

        // Halt has priority over branch
        Halt = 1'b1; BranchEn = 1'b1; BranchTarget = 10'd50;
        tick();
        check("halt_done", 32'(Done), 32'd1);
        check("halt_valid", 32'(InstValid), 32'd0);
        check("halt_addr", 32'(InstAddress), 32'd101);
        Halt = 1'b0; BranchTarget = 10'd200;
        tick();
        BranchEn = 1'b0;
        check("halted_br_ign", 32'(InstAddress), 32'd101);
        check("halted_valid", 32'(InstValid), 32'd0);
        check("halted_done", 32'(Done), 32'd1);

        // Restart at 0
        Start = 1'b1; StartAddr = 10'd0;
        tick();
        Start = 1'b0;
        check("restart_done", 32'(Done), 32'd0);
        check("restart_addr", 32'(InstAddress), 32'd0);
        tick();
        check("restart_pc", 32'(PcOut), 32'd0);
        check("restart_valid", 32'(InstValid), 32'd1);

        // Start while running is ignored
        Start = 1'b1; StartAddr = 10'd300;
        tick();
        Start = 1'b0;
        check("run_start_ign", 32'(PcOut), 32'd1);

        // Wrap from 1023
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        Start = 1'b1; StartAddr = 10'd1023;
        tick();
        Start = 1'b0;
        tick();
        check("wrap_pc0", 32'(PcOut), 32'd1023);
        check("wrap_inst0", 32'(InstOut), 32'h0AA);
        tick();
        check("wrap_pc1", 32'(PcOut), 32'd0);
        tick();
        check("wrap_pc2", 32'(PcOut), 32'd1);

        // Asynchronous reset between edges
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_valid", 32'(InstValid), 32'd0);
        check("async_pc", 32'(PcOut), 32'd0);
        check("async_inst", 32'(InstOut), 32'd0);
        check("async_addr", 32'(InstAddress), 32'd0);
`ifdef FETCH_INST_CNT_EN
        check("async_count", InstCount, 32'd0);
`endif
        tick();
        Reset_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(InstValid), 32'd0);
        check("post_rst_addr", 32'(InstAddress), 32'd0);

        // Four accepted instructions from 10
        Start = 1'b1; StartAddr = 10'd10; InstReady = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        InstReady = 1'b0;
        check("cnt_seq_pc", 32'(PcOut), 32'd14);
`ifdef FETCH_INST_CNT_EN
        check("cnt_four", InstCount, 32'd4);
        tick();
        check("cnt_hold", InstCount, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
